// File: rtl/sfx_pkg.sv
// Shared types and effect address tables for the event-triggered SFX player.
// The tables mirror the sample ROM .coe layout; index 0 is the highest priority.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } sfx_state_t;

    typedef logic [1:0] sfx_id_t;

    localparam logic [7:0] SILENCE = 8'h80;

    // Packed as {id3, id2, id1, id0}; id3 deliberately straddles the top of the ROM.
    localparam logic [3:0][17:0] SFX_START = {18'h3FFFE, 18'h00200, 18'h00100, 18'h00010};
    localparam logic [3:0][17:0] SFX_LEN   = {18'd6,     18'd4,     18'd5,     18'd3};

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-clock strobe every DIV clocks.
// The strobe is high while the count sits at DIV-1.
module sample_tick_gen #(
    parameter int DIV = 6250
) (
    input  logic clk,
    input  logic rst,
    output logic sample_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_tick = (cnt_q == LAST);

endmodule

// File: rtl/sfx_trigger_player.sv
// One-shot sound-effect player: priority-arbitrates event pulses on each sample
// tick, walks the chosen effect's ROM range and latches PCM for the PWM stage.
module sfx_trigger_player
    import sfx_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SAMPLE_HZ = 16_000,
    parameter int ADDR_W    = 18,
    parameter int NUM_SFX   = 4,
    parameter int ROM_LAT   = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_SFX-1:0]         trigger,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [7:0]                 rom_data,
    output logic [7:0]                 audio_sample_out,
    output logic                       sample_tick,
    output logic                       busy,
    output logic [$clog2(NUM_SFX)-1:0] active_id,
    output sfx_state_t                 state_dbg
);

    localparam int DIV  = CLK_HZ / SAMPLE_HZ;
    localparam int ID_W = $clog2(NUM_SFX);

    sfx_state_t         state_q, state_d;
    logic [NUM_SFX-1:0] pending_q, pending_d, pend_all;
    logic [ADDR_W-1:0]  cur_q, cur_d, end_q, end_d, rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]  start_addr, start_end, fetch_addr, fetch_end;
    logic [ID_W-1:0]    active_q, active_d, sel_id;
    logic [7:0]         audio_q, audio_d;
    logic               busy_q, busy_d;
    logic [ROM_LAT:0]   strb_q, strb_d;
    logic [17:0]        sel_len;
    logic               sel_valid, start, fetch;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk         (CLK),
        .rst         (RESET),
        .sample_tick (sample_tick)
    );

    // Triggers landing in the tick cycle itself join that tick's arbitration.
    always_comb begin
        pend_all  = pending_q | trigger;
        sel_valid = |pend_all;
        sel_id    = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (pend_all[i]) sel_id = ID_W'(i);
        end
        sel_len    = SFX_LEN[sel_id];
        start_addr = ADDR_W'(SFX_START[sel_id]);
        start_end  = start_addr + ADDR_W'(sel_len) - ADDR_W'(1);
        // Only a running effect filters by priority; a draining one has finished.
        start      = sample_tick && sel_valid &&
                     ((state_q != PLAY) || (sel_id <= active_q));
    end

    always_comb begin
        if (start) assert (sel_len != '0);
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        end_d      = end_q;
        rom_addr_d = rom_addr_q;
        active_d   = active_q;
        fetch      = 1'b0;
        fetch_addr = cur_q;
        fetch_end  = end_q;

        if (start) begin
            fetch_addr = start_addr;
            fetch_end  = start_end;
            active_d   = sel_id;
        end

        if (sample_tick) begin
            if (start || (state_q == PLAY)) begin
                fetch      = 1'b1;
                rom_addr_d = fetch_addr;
                end_d      = fetch_end;
                if (fetch_addr == fetch_end) begin
                    state_d = DRAIN;
                end else begin
                    state_d = PLAY;
                    cur_d   = fetch_addr + ADDR_W'(1);
                end
            end else if (state_q == DRAIN) begin
                state_d = IDLE;
            end
        end

        pending_d = sample_tick ? '0 : pend_all;

        // The strobe reaches the top bit when rom_data holds the fetched byte.
        strb_d    = strb_q << 1;
        strb_d[0] = fetch;

        audio_d = audio_q;
        if (strb_q[ROM_LAT]) audio_d = rom_data;
        if (state_d == IDLE) audio_d = SILENCE;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            cur_q      <= '0;
            end_q      <= '0;
            rom_addr_q <= '0;
            active_q   <= '0;
            audio_q    <= SILENCE;
            busy_q     <= 1'b0;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cur_q      <= cur_d;
            end_q      <= end_d;
            rom_addr_q <= rom_addr_d;
            active_q   <= active_d;
            audio_q    <= audio_d;
            busy_q     <= busy_d;
            strb_q     <= strb_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign audio_sample_out = audio_q;
    assign busy             = busy_q;
    assign active_id        = active_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_sfx_trigger_player.sv
// Bench for sfx_trigger_player: ROM model, directed trigger scenarios and a
// per-tick scoreboard of {audio, busy, active_id} seen ROM_LAT+2 clocks after each tick.
module tb_sfx_trigger_player;

    localparam int CLK_HZ    = 320_000;
    localparam int SAMPLE_HZ = 16_000;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int ADDR_W    = 18;
    localparam int NUM_SFX   = 4;
    localparam int ROM_LAT   = 2;

    // Bench copy of the effect table.
    localparam logic [17:0] ST0 = 18'h00010;
    localparam logic [17:0] ST1 = 18'h00100;
    localparam logic [17:0] ST2 = 18'h00200;
    localparam logic [17:0] ST3 = 18'h3FFFE;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_SFX-1:0] trigger = '0;
    logic [ADDR_W-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic [7:0]         audio_sample_out;
    logic               sample_tick;
    logic               busy;
    logic [1:0]         active_id;
    sfx_pkg::sfx_state_t state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_cyc = 0;
    logic [10:0] exp_q[$];

    sfx_trigger_player #(
        .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .ADDR_W(ADDR_W),
        .NUM_SFX(NUM_SFX), .ROM_LAT(ROM_LAT)
    ) dut (
        .CLK              (clk),
        .RESET            (rst),
        .trigger          (trigger),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .audio_sample_out (audio_sample_out),
        .sample_tick      (sample_tick),
        .busy             (busy),
        .active_id        (active_id),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ROM model (two-register read pipeline) ----------------
    function automatic logic [7:0] rom_f(input logic [17:0] a);
        logic [17:0] off;
        if (a >= ST2 && a <= ST2 + 18'd3) begin
            off = a - ST2;
            return 8'(32'd10 * (32'(off) + 32'd1));
        end
        return a[7:0] ^ 8'hA5;
    endfunction

    logic [17:0] ra1 = '0;
    logic [17:0] ra2 = '0;
    always @(posedge clk) begin
        ra1 <= rom_addr;
        ra2 <= ra1;
    end
    assign rom_data = rom_f(ra2);

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic b, input logic [1:0] id);
        exp_q.push_back({a, b, id});
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sample_tick !== 1'b1 && n < 2 * DIV);
        if (sample_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual=none expected=tick within %0d clocks", 2 * DIV);
        end
        tick_cyc = cyc;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic pulse(input logic [NUM_SFX-1:0] v);
        trigger = v;
        @(negedge clk);
        trigger = '0;
    endtask

    task automatic mid_pulse(input logic [NUM_SFX-1:0] v);
        repeat (5) @(negedge clk);
        pulse(v);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [10:0] e;
        logic [10:0] a;
        forever begin
            @(negedge clk);
            if (sample_tick === 1'b1 && !rst) begin
                repeat (ROM_LAT + 2) @(negedge clk);
                if (!rst && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = {audio_sample_out, busy, active_id};
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL sb_sample actual audio=%0h busy=%0b id=%0d expected audio=%0h busy=%0b id=%0d",
                                 a[10:3], a[2], a[1:0], e[10:3], e[2], e[1:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int t0;
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_audio", 32'(audio_sample_out), 32'h80);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_tick", 32'(sample_tick), 32'd0);
        chk("rst_id", 32'(active_id), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(sfx_pkg::IDLE));
        rst = 1'b0;

        // Idle ticks and tick period
        wait_tick();
        t0 = tick_cyc;
        wait_tick();
        chk("tick_period1", 32'(tick_cyc - t0), 32'(DIV));
        t0 = tick_cyc;
        wait_tick();
        chk("tick_period2", 32'(tick_cyc - t0), 32'(DIV));
        chk("idle_audio", 32'(audio_sample_out), 32'h80);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_addr", 32'(rom_addr), 32'd0);

        // Effect 2: 10,20,30,40 then silence
        mid_pulse(4'b0100);
        wait_tick();
        push_exp(8'd10, 1'b1, 2'd2);
        push_exp(8'd20, 1'b1, 2'd2);
        push_exp(8'd30, 1'b1, 2'd2);
        push_exp(8'd40, 1'b1, 2'd2);
        push_exp(8'h80, 1'b0, 2'd2);
        push_exp(8'h80, 1'b0, 2'd2);
        @(negedge clk);
        chk("e2_first_addr", 32'(rom_addr), 32'(ST2));
        chk("e2_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("e2_latch_not_early", 32'(audio_sample_out), 32'h80);
        wait_ticks(5);

        // Lower priority ignored, higher priority restarts
        mid_pulse(4'b0100);
        wait_tick();
        push_exp(8'd10, 1'b1, 2'd2);
        mid_pulse(4'b1000);
        wait_tick();
        push_exp(8'd20, 1'b1, 2'd2);
        @(negedge clk);
        chk("low_prio_id", 32'(active_id), 32'd2);
        chk("low_prio_addr", 32'(rom_addr), 32'(ST2 + 18'd1));
        mid_pulse(4'b0001);
        wait_tick();
        push_exp(rom_f(ST0), 1'b1, 2'd0);
        push_exp(rom_f(ST0 + 18'd1), 1'b1, 2'd0);
        push_exp(rom_f(ST0 + 18'd2), 1'b1, 2'd0);
        push_exp(8'h80, 1'b0, 2'd0);
        @(negedge clk);
        chk("preempt_id", 32'(active_id), 32'd0);
        chk("preempt_addr", 32'(rom_addr), 32'(ST0));
        wait_ticks(3);

        // Simultaneous triggers plus one in the tick cycle: id 1 wins, rest cleared
        mid_pulse(4'b1010);
        wait_tick();
        trigger = 4'b0100;
        for (int i = 0; i < 5; i++) push_exp(rom_f(ST1 + 18'(i)), 1'b1, 2'd1);
        push_exp(8'h80, 1'b0, 2'd1);
        push_exp(8'h80, 1'b0, 2'd1);
        @(negedge clk);
        trigger = '0;
        chk("multi_id", 32'(active_id), 32'd1);
        wait_ticks(6);

        // Effect 3 wraps the address space; reset lands mid-effect
        mid_pulse(4'b1000);
        wait_tick();
        push_exp(rom_f(ST3), 1'b1, 2'd3);
        wait_tick();
        push_exp(rom_f(ST3 + 18'd1), 1'b1, 2'd3);
        @(negedge clk);
        chk("e3_addr_top", 32'(rom_addr), 32'h3FFFF);
        wait_tick();
        push_exp(rom_f(18'h0), 1'b1, 2'd3);
        @(negedge clk);
        chk("e3_addr_wrap", 32'(rom_addr), 32'd0);
        wait_tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_audio", 32'(audio_sample_out), 32'h80);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(rom_addr), 32'd0);
        chk("midrst_id", 32'(active_id), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (audio_sample_out !== 8'h80 || busy !== 1'b0) bad++;
        end
        chk("no_late_latch", 32'(bad), 32'd0);

        // Retrigger on the drain tick: no silence gap
        mid_pulse(4'b0001);
        wait_tick();
        push_exp(rom_f(ST0), 1'b1, 2'd0);
        push_exp(rom_f(ST0 + 18'd1), 1'b1, 2'd0);
        push_exp(rom_f(ST0 + 18'd2), 1'b1, 2'd0);
        wait_ticks(3);
        trigger = 4'b0001;
        push_exp(rom_f(ST0), 1'b1, 2'd0);
        push_exp(rom_f(ST0 + 18'd1), 1'b1, 2'd0);
        push_exp(rom_f(ST0 + 18'd2), 1'b1, 2'd0);
        push_exp(8'h80, 1'b0, 2'd0);
        @(negedge clk);
        trigger = '0;
        chk("retrig_addr", 32'(rom_addr), 32'(ST0));
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (audio_sample_out === 8'h80) bad++;
        end
        chk("retrig_no_gap", 32'(bad), 32'd0);
        wait_ticks(3);
        repeat (ROM_LAT + 4) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
